block_ram_ext: RTL and testbench

BLOCK_RAM_EXT -- requirements
Module: block_ram_ext

---
 rtl/block_ram_ext.sv | 117 +++++++++++
 tb/tb_block_ram_ext.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_ram_ext.sv
// rtl/block_ram_ext.sv - lane-masked simple dual-port block RAM with zero-fill after reset
module block_ram_ext #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 256,
  parameter int LANES          = 4,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     wr_en,
  input  logic [LANES-1:0]         wr_lane_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     busy
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              LW      = WIDTH / LANES;
  localparam logic [AW:0]     DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t            state, state_nxt;
  logic [AW-1:0]     clr_cnt, clr_cnt_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_word;
  logic              en, ready, wr_hit, rd_take, rd_in_range;

  // Memory must not change while reset is held, so rst_n also gates the enable.
  assign en          = clk_en & rst_n;
  assign ready       = (state == READY);
  assign busy        = (state == CLEAR);
  assign wr_hit      = en & ready & wr_en & ({1'b0, wr_addr} < DEPTH_W);
  assign rd_take     = ready & rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else if (clk_en) begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == CLEAR) begin
      if (clr_cnt == LAST) state_nxt = READY;
      else                 clr_cnt_nxt = clr_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en && state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_lane_en[i]) mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
      end
    end
  end

  // Out-of-range reads return zero; write-first forwards only the enabled lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (WRITE_FIRST != 0 && wr_hit && wr_addr == rd_addr) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_lane_en[i]) rd_word[i*LW +: LW] = wr_data[i*LW +: LW];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_rl2
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (clk_en) begin
        s1_valid <= rd_take;
        if (rd_take) s1_data <= rd_word;
        rd_valid <= s1_valid;
        if (s1_valid) rd_data <= s1_data;
      end
    end
  end else begin : g_rl1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (clk_en) begin
        rd_valid <= rd_take;
        if (rd_take) rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_block_ram_ext.sv
// tb/tb_block_ram_ext.sv - self-checking bench for block_ram_ext across five parameter sets
module tb_block_ram_ext;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, wr_en, rd_en;
  logic [3:0]  wr_lane_en, wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data_o  [N];
  logic        rd_valid_o [N];
  logic        busy_o     [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: WF0 RL1, u1: WF1 RL1, u2: WF0 RL2, u3: DEPTH12 WF1 RL2, u4: no clear
  for (genvar g = 0; g < N; g++) begin : g_dut
    block_ram_ext #(
      .WIDTH(32), .DEPTH(g == 3 ? 12 : 16), .LANES(4),
      .RD_LATENCY((g == 2 || g == 3) ? 2 : 1),
      .WRITE_FIRST((g == 1 || g == 3) ? 1 : 0),
      .CLEAR_ON_RESET(g == 4 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en),
      .wr_lane_en(wr_lane_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_o[g]), .rd_valid(rd_valid_o[g]), .busy(busy_o[g])
    );
  end

  function automatic int depth_of(input int k); return (k == 3) ? 12 : 16; endfunction
  function automatic int rl_of(input int k);    return (k == 2 || k == 3) ? 2 : 1; endfunction
  function automatic bit wf_of(input int k);    return (k == 1 || k == 3); endfunction
  function automatic bit clr_of(input int k);   return (k != 4); endfunction

  // Reference model: memory contents, words left to clear, and per-instance result delay line.
  logic [31:0] m_mem [N][16];
  int          m_clr_left [N];
  logic [31:0] m_data [N];
  logic        m_valid [N];
  logic [31:0] m_pend_d [N];
  logic        m_pend_v [N];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_clr_left[k] = clr_of(k) ? depth_of(k) : 0;
      m_data[k]     = '0;
      m_valid[k]    = 1'b0;
      m_pend_v[k]   = 1'b0;
      m_pend_d[k]   = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      logic        rv;
      logic [31:0] rdv;
      rv  = 1'b0;
      rdv = '0;
      if (m_clr_left[k] > 0) begin
        m_mem[k][depth_of(k) - m_clr_left[k]] = '0;
        m_clr_left[k]--;
      end else begin
        rv = rd_en;
        if (int'(rd_addr) < depth_of(k)) rdv = m_mem[k][rd_addr];
        if (wf_of(k) && wr_en && wr_addr == rd_addr && int'(wr_addr) < depth_of(k))
          rdv = merge(rdv, wr_data, wr_lane_en);
        if (wr_en && int'(wr_addr) < depth_of(k))
          m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_data, wr_lane_en);
      end
      if (rl_of(k) == 1) begin
        m_valid[k] = rv;
        if (rv) m_data[k] = rdv;
      end else begin
        m_valid[k] = m_pend_v[k];
        if (m_pend_v[k]) m_data[k] = m_pend_d[k];
        m_pend_v[k] = rv;
        m_pend_d[k] = rdv;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, step the model on the rising edge, compare at the next falling edge.
  task automatic cycle(input logic ce, input logic rstn, input logic we, input logic [3:0] lanes,
                       input logic [3:0] wa, input logic [31:0] wd, input logic re,
                       input logic [3:0] ra);
    clk_en = ce; rst_n = rstn; wr_en = we; wr_lane_en = lanes;
    wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    if (!rstn) model_reset();
    @(posedge clk);
    if (rstn && ce) model_step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d busy", k), 32'(busy_o[k]), 32'(m_clr_left[k] > 0));
      chk($sformatf("u%0d rd_valid", k), 32'(rd_valid_o[k]), 32'(m_valid[k]));
      if (k != 4) chk($sformatf("u%0d rd_data", k), rd_data_o[k], m_data[k]);
    end
  endtask

  task automatic idle(input logic ce = 1'b1); cycle(ce, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0); endtask
  task automatic rd(input logic [3:0] a);     cycle(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a); endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, 1'b1, 4'hF, a, d, 1'b0, 4'h0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  lanes;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic        exp_v;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < N; k++) for (int a = 0; a < 16; a++) m_mem[k][a] = '0;

    // exp_a: write-old (u0); exp_b: write-first (u1); both single-cycle latency
    vecs[0] = '{1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0,  1'b0, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 4'h5, 4'd3,  32'h11223344, 1'b0, 4'd0,  1'b0, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd3,  1'b1, 32'hDE22BE44, 32'hDE22BE44};
    vecs[3] = '{1'b1, 4'hF, 4'd3,  32'hCAFEF00D, 1'b1, 4'd3,  1'b1, 32'hDE22BE44, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd3,  1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 4'h0, 4'd3,  32'h12345678, 1'b1, 4'd3,  1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b0, 4'd0,  1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 4'hF, 4'd13, 32'hFFFFFFFF, 1'b0, 4'd0,  1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[8] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd13, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    chk("reset busy", 32'(busy_o[0]), 32'd1);
    chk("reset busy no-clear", 32'(busy_o[4]), 32'd0);
    chk("reset rd_valid", 32'(rd_valid_o[0]), 32'd0);
    chk("reset rd_data", rd_data_o[0], 32'h0);

    // Clear lasts exactly DEPTH enabled edges
    n = 0;
    do begin idle(); n++; end while (busy_o[0] && n < 40);
    chk("clear edges", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("cleared word", rd_data_o[0], 32'h0);
      chk("cleared valid", 32'(rd_valid_o[0]), 32'd1);
    end

    foreach (vecs[i]) begin
      cycle(1'b1, 1'b1, vecs[i].we, vecs[i].lanes, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      chk($sformatf("vec%0d valid", i), 32'(rd_valid_o[0]), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d data wf0", i), rd_data_o[0], vecs[i].exp_a);
      chk($sformatf("vec%0d data wf1", i), rd_data_o[1], vecs[i].exp_b);
    end

    // Two-cycle latency with a clock-enable gap
    wr(4'd1, 32'h01010101);
    wr(4'd2, 32'h02020202);
    rd(4'd3); idle();
    chk("rl2 pre", rd_data_o[2], 32'hCAFEF00D);
    rd(4'd1);
    chk("rl2 e1 valid", 32'(rd_valid_o[2]), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 4'hF, 4'd1, 32'h0, 1'b1, 4'd5);
    chk("rl2 gap valid", 32'(rd_valid_o[2]), 32'd0);
    chk("rl2 gap data", rd_data_o[2], 32'hCAFEF00D);
    rd(4'd2);
    chk("rl2 r1 valid", 32'(rd_valid_o[2]), 32'd1);
    chk("rl2 r1 data", rd_data_o[2], 32'h01010101);
    cycle(1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    chk("rl2 frozen valid", 32'(rd_valid_o[2]), 32'd1);
    chk("rl2 frozen data", rd_data_o[2], 32'h01010101);
    idle();
    chk("rl2 r2 data", rd_data_o[2], 32'h02020202);
    idle();
    chk("rl2 done valid", 32'(rd_valid_o[2]), 32'd0);

    // DEPTH=12: out-of-range write dropped, out-of-range read returns zero
    rd(4'd3); idle();
    chk("d12 pre", rd_data_o[3], 32'hCAFEF00D);
    rd(4'd13); idle();
    chk("d12 oor valid", 32'(rd_valid_o[3]), 32'd1);
    chk("d12 oor data", rd_data_o[3], 32'h0);
    for (int a = 0; a <= 12; a++) begin
      if (a < 12) rd(4'(a)); else idle();
      if (a > 0) begin
        chk("d12 word", rd_data_o[3], (a - 1 == 3) ? 32'hCAFEF00D :
                                      (a - 1 == 1) ? 32'h01010101 :
                                      (a - 1 == 2) ? 32'h02020202 : 32'h0);
        chk("d12 stream valid", 32'(rd_valid_o[3]), 32'd1);
      end
    end

    // Reset pulse mid-clear restarts the fill from address 0
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) idle(i != 3);
    chk("midclear busy", 32'(busy_o[0]), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd0);
    chk("midclear rst busy", 32'(busy_o[0]), 32'd1);
    chk("midclear rst valid", 32'(rd_valid_o[2]), 32'd0);
    n = 0;
    do begin idle(); n++; end while (busy_o[0] && n < 40);
    chk("reclear edges", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("recleared word", rd_data_o[0], 32'h0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 32'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
